// File: rtl/mlp_layer_sequencer_if.sv
// Bus between one MLP layer sequencer and its layer memories, MAC and the
// top-level MLP control.
//
// Handshake: start/done is a pulse handshake, not valid/ready. The control
// raises start for one or more cycles; it is accepted only while busy is low.
// Acceptance is seen as busy rising on the next cycle. done is a single-cycle
// pulse on the last busy cycle. start seen while busy is high is dropped, not
// queued. Memory reads have a fixed one-cycle latency with no stall.
// dbg_state exposes the sequencer FSM state for checkers.
interface mlp_layer_sequencer_if #(
    parameter int W      = 32,
    parameter int IN_AW  = 10,
    parameter int OUT_AW = 4,
    parameter int W_AW   = 13
);
    logic              start;
    logic              busy;
    logic              done;
    logic [IN_AW-1:0]  in_addr;
    logic [W_AW-1:0]   w_addr;
    logic [OUT_AW-1:0] b_addr;
    logic              mac_clr;
    logic              mac_en;
    logic [W-1:0]      acc_in;
    logic              out_we;
    logic [OUT_AW-1:0] out_addr;
    logic [W-1:0]      out_data;
    logic [2:0]        dbg_state;

    // Sequencer side
    modport master (
        input  start, acc_in,
        output busy, done, in_addr, w_addr, b_addr, mac_clr, mac_en,
               out_we, out_addr, out_data, dbg_state
    );

    // Control / memory / MAC side
    modport slave (
        output start, acc_in,
        input  busy, done, in_addr, w_addr, b_addr, mac_clr, mac_en,
               out_we, out_addr, out_data, dbg_state
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Control FSM for one fully-connected MLP layer on a shared single-MAC
// datapath: per neuron BIAS (1) + RUN (N_IN) + DRAIN (1) + WB (1) cycles,
// then a one-cycle DONE pulse.
// Optional feature macro: MLP_SEQ_RELU_EN -- when defined the written value
// is ReLU(acc_in); otherwise acc_in is written unchanged.
module mlp_layer_sequencer #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 10,
    parameter int W      = 32,
    parameter int IN_AW  = 10,
    parameter int OUT_AW = 4,
    parameter int W_AW   = 13
) (
    input  logic                   CLK,
    input  logic                   reset,
    mlp_layer_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [IN_AW-1:0]  LAST_I = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] LAST_N = OUT_AW'(N_OUT - 1);

    state_t            state_q, state_d;
    logic [OUT_AW-1:0] neuron_q, neuron_d;
    logic [IN_AW-1:0]  i_q, i_d;
    // Running weight address; avoids a neuron*N_IN multiplier.
    logic [W_AW-1:0]   w_q, w_d;
    logic [W-1:0]      act;

    // State and counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            neuron_q <= '0;
            i_q      <= '0;
            w_q      <= '0;
        end else begin
            state_q  <= state_d;
            neuron_q <= neuron_d;
            i_q      <= i_d;
            w_q      <= w_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d  = state_q;
        neuron_d = neuron_q;
        i_d      = i_q;
        w_d      = w_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_BIAS;
                    neuron_d = '0;
                    w_d      = '0;
                end
            end
            S_BIAS: begin
                state_d = S_RUN;
                i_d     = '0;
            end
            S_RUN: begin
                w_d = w_q + W_AW'(1);
                if (i_q == LAST_I) begin
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + IN_AW'(1);
                end
            end
            S_DRAIN: state_d = S_WB;
            S_WB: begin
                if (neuron_q == LAST_N) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_BIAS;
                    neuron_d = neuron_q + OUT_AW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Activation applied to the accumulator on the write-back path
`ifdef MLP_SEQ_RELU_EN
    assign act = bus.acc_in[W-1] ? '0 : bus.acc_in;
`else
    assign act = bus.acc_in;
`endif

    // Moore outputs decoded from the current state; zero outside their states
    always_comb begin
        bus.busy     = (state_q != S_IDLE);
        bus.done     = (state_q == S_DONE);
        bus.in_addr  = '0;
        bus.w_addr   = '0;
        bus.b_addr   = '0;
        bus.mac_clr  = 1'b0;
        bus.mac_en   = 1'b0;
        bus.out_we   = 1'b0;
        bus.out_addr = '0;
        bus.out_data = '0;
        bus.dbg_state = state_q;
        unique case (state_q)
            S_BIAS: bus.b_addr = neuron_q;
            S_RUN: begin
                bus.in_addr = i_q;
                bus.w_addr  = w_q;
                // First RUN cycle loads the bias that BIAS fetched; later
                // cycles accumulate the product fetched one cycle earlier.
                bus.mac_clr = (i_q == '0);
                bus.mac_en  = (i_q != '0);
            end
            // Last product arrives one cycle after the last RUN address.
            S_DRAIN: bus.mac_en = 1'b1;
            S_WB: begin
                bus.out_we   = 1'b1;
                bus.out_addr = neuron_q;
                bus.out_data = act;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench for mlp_layer_sequencer: a small 4x3 instance checked
// cycle by cycle against a schedule built from nested neuron/input loops, and
// a default 784x10 instance checked for results, counts and done timing.
module tb_mlp_layer_sequencer;
    localparam int W       = 32;
    localparam int SN_IN   = 4;
    localparam int SN_OUT  = 3;
    localparam int SIN_AW  = 2;
    localparam int SOUT_AW = 2;
    localparam int SW_AW   = 4;
    localparam int S_DONE_CYC = SN_OUT * (SN_IN + 3) + 1;
`ifdef MLP_SEQ_RELU_EN
    localparam logic [W-1:0] NEG_RESULT = 32'h0000_0000;
`else
    localparam logic [W-1:0] NEG_RESULT = 32'hFFFF_FFF0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mlp_layer_sequencer_if #(.W(W), .IN_AW(SIN_AW), .OUT_AW(SOUT_AW), .W_AW(SW_AW)) s_if();
    mlp_layer_sequencer_if #(.W(W), .IN_AW(10), .OUT_AW(4), .W_AW(13)) b_if();

    mlp_layer_sequencer #(.N_IN(SN_IN), .N_OUT(SN_OUT), .W(W), .IN_AW(SIN_AW),
                          .OUT_AW(SOUT_AW), .W_AW(SW_AW))
        u_small (.CLK(clk), .reset(reset), .bus(s_if.master));

    mlp_layer_sequencer u_big (.CLK(clk), .reset(reset), .bus(b_if.master));

    // ---------------- memories and MAC around the DUTs ----------------
    logic [W-1:0] in_mem [SN_IN];
    logic [W-1:0] w_mem  [16];
    logic [W-1:0] b_mem  [4];
    logic [W-1:0] in_rd, w_rd, b_rd, acc_s, acc_b;

    always @(posedge clk) begin
        in_rd <= in_mem[s_if.in_addr];
        w_rd  <= w_mem[s_if.w_addr];
        b_rd  <= b_mem[s_if.b_addr];
        if (s_if.mac_clr) acc_s <= b_rd;
        else if (s_if.mac_en) acc_s <= acc_s + in_rd * w_rd;
        // Big layer: biases 0, inputs 1, weights 1
        if (b_if.mac_clr) acc_b <= '0;
        else if (b_if.mac_en) acc_b <= acc_b + 32'd1;
    end
    assign s_if.acc_in = acc_s;
    assign b_if.acc_in = acc_b;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic               busy;
        logic               done;
        logic [SIN_AW-1:0]  in_addr;
        logic [SW_AW-1:0]   w_addr;
        logic [SOUT_AW-1:0] b_addr;
        logic               mac_clr;
        logic               mac_en;
        logic               out_we;
        logic [SOUT_AW-1:0] out_addr;
        logic [W-1:0]       out_data;
    } trace_t;

    trace_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_clr, cnt_en, cnt_done, cnt_we, done_cyc;
    logic [W-1:0] wb0_data;

    function automatic logic [W-1:0] act(input logic [W-1:0] a);
`ifdef MLP_SEQ_RELU_EN
        return a[W-1] ? '0 : a;
`else
        return a;
`endif
    endfunction

    function automatic trace_t observe();
        trace_t t;
        t.busy     = s_if.busy;
        t.done     = s_if.done;
        t.in_addr  = s_if.in_addr;
        t.w_addr   = s_if.w_addr;
        t.b_addr   = s_if.b_addr;
        t.mac_clr  = s_if.mac_clr;
        t.mac_en   = s_if.mac_en;
        t.out_we   = s_if.out_we;
        t.out_addr = s_if.out_addr;
        t.out_data = s_if.out_data;
        return t;
    endfunction

    function automatic logic big_quiet();
        return !(b_if.busy | b_if.done | b_if.mac_clr | b_if.mac_en | b_if.out_we |
                 (|b_if.in_addr) | (|b_if.w_addr) | (|b_if.b_addr) |
                 (|b_if.out_addr) | (|b_if.out_data));
    endfunction

    // Expected per-cycle schedule of one layer, from the layer's own arithmetic
    task automatic build_layer();
        trace_t t;
        for (int n = 0; n < SN_OUT; n++) begin
            logic [W-1:0] sum;
            sum = b_mem[n];
            for (int i = 0; i < SN_IN; i++) sum = sum + in_mem[i] * w_mem[n * SN_IN + i];
            t = '0; t.busy = 1'b1; t.b_addr = SOUT_AW'(n);
            exp_q.push_back(t);
            for (int i = 0; i < SN_IN; i++) begin
                t = '0; t.busy = 1'b1;
                t.in_addr = SIN_AW'(i);
                t.w_addr  = SW_AW'(n * SN_IN + i);
                t.mac_clr = (i == 0);
                t.mac_en  = (i != 0);
                exp_q.push_back(t);
            end
            t = '0; t.busy = 1'b1; t.mac_en = 1'b1;
            exp_q.push_back(t);
            t = '0; t.busy = 1'b1; t.out_we = 1'b1; t.out_addr = SOUT_AW'(n);
            t.out_data = act(sum);
            exp_q.push_back(t);
        end
        t = '0; t.busy = 1'b1; t.done = 1'b1;
        exp_q.push_back(t);
        exp_q.push_back('0);
    endtask

    task automatic randomize_mems();
        for (int i = 0; i < SN_IN; i++) in_mem[i] = $urandom_range(0, 255) - 128;
        for (int i = 0; i < 16; i++) w_mem[i] = $urandom_range(0, 255) - 128;
        for (int i = 0; i < 4; i++) b_mem[i] = $urandom;
    endtask

    // ---------------- driver: one layer on the small instance ----------------
    // Called at a negedge; start is raised immediately (first IDLE cycle).
    task automatic run_layer(input bit noise, input bit start_in_done, input int abort_cyc);
        trace_t got, exp;
        int cyc;
        build_layer();
        cnt_clr = 0; cnt_en = 0; cnt_done = 0; cnt_we = 0; done_cyc = -1;
        wb0_data = 'x;
        s_if.start = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            got = observe();
            exp = exp_q.pop_front();
            if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
                exp = '0;
                exp_q.delete();
                repeat (3) exp_q.push_back('0);
                reset = 1'b0;
            end
            n_cmp++;
            assert (got === exp) else begin
                n_bad++;
                $error("FAIL trace cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
            if (got.mac_clr) cnt_clr++;
            if (got.mac_en) cnt_en++;
            if (got.out_we) cnt_we++;
            if (got.done) begin cnt_done++; done_cyc = cyc; end
            if (got.out_we && got.out_addr == '0) wb0_data = got.out_data;
            if (cyc == abort_cyc) begin
                reset = 1'b1;
                s_if.start = 1'b0;
            end else if (exp.done) s_if.start = start_in_done;
            else if (exp.busy && noise) s_if.start = 1'($urandom_range(0, 1));
            else s_if.start = 1'b0;
        end
        if (abort_cyc == 0) begin
            n_cmp++;
            assert (cnt_clr === 3) else begin n_bad++; $error("FAIL clr_count got=%0d exp=3", cnt_clr); end
            n_cmp++;
            assert (cnt_en === 12) else begin n_bad++; $error("FAIL en_count got=%0d exp=12", cnt_en); end
            n_cmp++;
            assert (cnt_we === SN_OUT) else begin n_bad++; $error("FAIL we_count got=%0d exp=%0d", cnt_we, SN_OUT); end
            n_cmp++;
            assert (cnt_done === 1 && done_cyc === S_DONE_CYC) else begin
                n_bad++;
                $error("FAIL done_cycle got=%0d (count %0d) exp=%0d", done_cyc, cnt_done, S_DONE_CYC);
            end
        end else begin
            n_cmp++;
            assert (cnt_done === 0) else begin n_bad++; $error("FAIL abort_done got=%0d exp=0", cnt_done); end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc, big_done, big_we, big_en;
        reset = 1'b1;
        s_if.start = 1'b1;
        b_if.start = 1'b1;

        // Reset held with start high: everything quiet
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            assert (observe() === trace_t'('0)) else begin
                n_bad++; $error("FAIL reset_small got=%h exp=0", observe());
            end
            n_cmp++;
            assert (big_quiet() === 1'b1) else begin n_bad++; $error("FAIL reset_big got=busy %b exp=quiet", b_if.busy); end
        end
        reset = 1'b0;
        s_if.start = 1'b0;
        b_if.start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            assert (observe() === trace_t'('0)) else begin
                n_bad++; $error("FAIL idle_after_reset got=%h exp=0", observe());
            end
        end

        // Plain layer with random data
        randomize_mems();
        run_layer(1'b0, 1'b0, 0);

        // start noise mid-layer and in the done cycle, then back-to-back start
        randomize_mems();
        run_layer(1'b1, 1'b1, 0);
        randomize_mems();
        run_layer(1'b0, 1'b0, 0);

        // Negative accumulator on neuron 0
        randomize_mems();
        for (int i = 0; i < SN_IN; i++) w_mem[i] = '0;
        b_mem[0] = 32'hFFFF_FFF0;
        run_layer(1'b0, 1'b0, 0);
        n_cmp++;
        assert (wb0_data === NEG_RESULT) else begin
            n_bad++; $error("FAIL neg_activation got=%h exp=%h", wb0_data, NEG_RESULT);
        end

        // Reset in the 2nd RUN cycle of neuron 1, then a full fresh layer
        randomize_mems();
        run_layer(1'b0, 1'b0, SN_IN + 3 + 3);
        randomize_mems();
        run_layer(1'b1, 1'b0, 0);

        // Default-size layer
        b_if.start = 1'b1;
        cyc = 0; big_done = -1; big_we = 0; big_en = 0;
        while (big_done < 0 && cyc < 9000) begin
            @(negedge clk);
            cyc++;
            b_if.start = 1'b0;
            if (b_if.out_we) begin
                n_cmp++;
                assert (b_if.out_data === 32'd784 && b_if.out_addr === 4'(big_we)) else begin
                    n_bad++;
                    $error("FAIL big_wb got=%0d@%0d exp=784@%0d", b_if.out_data, b_if.out_addr, big_we);
                end
                big_we++;
            end
            if (b_if.mac_en) big_en++;
            if (b_if.done) big_done = cyc;
        end
        n_cmp++;
        assert (big_done === 7871) else begin n_bad++; $error("FAIL big_done_cycle got=%0d exp=7871", big_done); end
        n_cmp++;
        assert (big_we === 10) else begin n_bad++; $error("FAIL big_we_count got=%0d exp=10", big_we); end
        n_cmp++;
        assert (big_en === 7840) else begin n_bad++; $error("FAIL big_en_count got=%0d exp=7840", big_en); end
        @(negedge clk);
        n_cmp++;
        assert (big_quiet() === 1'b1) else begin n_bad++; $error("FAIL big_idle got=busy %b exp=quiet", b_if.busy); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

Control FSM that runs one fully-connected MLP layer on a shared single-MAC datapath. After a `start` pulse it walks every output neuron and every input. It issues input-buffer, weight-ROM and bias-ROM read addresses and drives the accumulator clear/enable strobes. It then writes each neuron's result into the layer output buffer. It sits between the top-level MLP control (one instance per layer, chained via `start`/`done`) and the memories and MAC of that layer.

## Interface
- `N_IN`, 784, inputs per neuron (≥2)
- `N_OUT`, 10, neurons in the layer (≥1)
- `W`, 32, data word width
- `IN_AW`, 10, input-buffer address width, ≥ clog2(N_IN)
- `OUT_AW`, 4, bias/output address width, ≥ clog2(N_OUT)
- `W_AW`, 13, weight address width, ≥ clog2(N_IN*N_OUT)

Ports:
- `CLK`  in  1  clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a layer; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive
- `done`  out  1  one-cycle pulse when all neurons are written
- `in_addr`  out  IN_AW  input-buffer read address
- `w_addr`  out  W_AW  weight-ROM read address = neuron*N_IN + i
- `b_addr`  out  OUT_AW  bias-ROM read address
- `mac_clr`  out  1  load the accumulator with the bias-ROM data this cycle
- `mac_en`  out  1  accumulator += in_data*w_data this cycle
- `acc_in`  in  W  accumulator value (two's complement), fed back from the MAC
- `out_we`  out  1  output-buffer write enable
- `out_addr`  out  OUT_AW  output-buffer write address (neuron index)
- `out_data`  out  W  output-buffer write data

## Operation
- All memories have 1-cycle read latency: an address presented in cycle t returns data in cycle t+1.
- States and transitions:
  - IDLE: `start` → BIAS with neuron=0.
  - BIAS: 1 cycle; `b_addr`=neuron → RUN with i=0.
  - RUN: N_IN cycles; `in_addr`=i, `w_addr`=neuron*N_IN+i, i increments; after i=N_IN−1 → DRAIN.
  - DRAIN: 1 cycle → WB.
  - WB: 1 cycle; `out_we`=1, `out_addr`=neuron. If neuron=N_OUT−1 → DONE, else neuron+1 → BIAS.
  - DONE: `done`=1 for 1 cycle → IDLE.
- Strobes within each neuron:
  - `mac_clr`=1 in the first RUN cycle only.
  - `mac_en`=1 in RUN cycles 2..N_IN and in DRAIN, i.e. exactly N_IN cycles per neuron.
  - `mac_clr` and `mac_en` are never high in the same cycle.
- `w_addr` is kept in a running counter, not computed with a multiplier. It increments by 1 every RUN cycle across neuron boundaries and resets to 0 only on leaving IDLE.
- `out_data` in WB = activation(`acc_in`), combinational from `acc_in`. `out_data` is 0 whenever `out_we`=0.
- Address outputs are 0 outside the states that drive them.
- `start` outside IDLE is ignored; it is not queued.

## Timing
- Reset: state=IDLE. All outputs are 0 (`busy`, `done`, `mac_clr`, `mac_en`, `out_we`, all addresses, `out_data`).
- Reset mid-layer: the FSM returns to IDLE at the same edge and all outputs are 0 the next cycle. No further `out_we`, and no `done` for the aborted layer.
- `start` high at edge e0 (in IDLE): BIAS occupies cycle 1. The layer uses N_OUT*(N_IN+3) cycles, and `done` is high in cycle N_OUT*(N_IN+3)+1. With defaults: 7870 work cycles, `done` in cycle 7871.
- Back-to-back layers: `start` asserted in the cycle `done` is high is ignored. The earliest accepted `start` is the cycle after `done`, i.e. the first IDLE cycle.
- `busy` = (state ≠ IDLE).

## Configuration
- `MLP_SEQ_RELU_EN` defined: in WB, `out_data` = 0 if `acc_in[W-1]`=1, else `acc_in` (ReLU).
- Not defined: `out_data` = `acc_in` unchanged (linear output layer).
- Cycle timing is identical either way.

## Test plan
1. Reset held 3 cycles with `start`=1 → all outputs 0, `busy`=0, no state change; release reset → still IDLE until the next `start`.
2. N_IN=4, N_OUT=3, one `start` pulse → `w_addr` sequence 0..11 over the RUN cycles. `mac_clr` count = 3, `mac_en` count = 12, `out_we` at `out_addr` 0,1,2. `done` in cycle 22 only.
3. Defaults, model MAC with biases=0, all inputs=1, weights=1 → each `out_data`=784 (0x310). `done` in cycle 7871.
4. `MLP_SEQ_RELU_EN` defined, `acc_in`=0xFFFFFFF0 in WB → `out_data`=0. Macro undefined, same stimulus → `out_data`=0xFFFFFFF0.
5. `start` re-pulsed mid-layer and in the `done` cycle → ignored (single `done`, write count = N_OUT). `start` in the following cycle → new layer begins with `b_addr`=0.
6. Reset asserted in the 2nd RUN cycle of neuron 1 → next cycle IDLE with all outputs 0. A subsequent `start` runs a complete layer starting at neuron 0, `w_addr`=0.
